decoder_one_of_8_to_bcd: RTL and testbench
==========================================

# decoder_one_of_8_to_bcd

Registered one-hot-to-BCD encoder: converts an 8-bit one-hot code (bit i set means value i) into a 4-bit BCD digit 0–7. It also flags malformed codes (no bit set or more than one bit set). It sits between one-hot state or select logic and BCD display/readout paths. Outputs are registered with one cycle of latency, and a sticky error flag is provided for status registers.

## Interface
- Parameters: none.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low; one clock domain only.
- in_valid  input  1  qualifies one_of_8 for the current cycle.
- one_of_8  input  8  one-hot code; bit i set means decimal value i.
- err_clr  input  1  synchronous clear of err_sticky.
- bcd  output  4  registered BCD digit 0–7, or 4'hF on a malformed code.
- out_valid  output  1  registered copy of in_valid; bcd/error are meaningful while high.
- error  output  1  registered; high when the captured code was not exactly one-hot.
- err_sticky  output  1  set by any captured malformed code; held until err_clr or reset.

## Operation
- Decode, for a well-formed input:
  - 8'b0000_0001 -> 0
  - 8'b0000_0010 -> 1
  - 8'b0000_0100 -> 2
  - 8'b0000_1000 -> 3
  - 8'b0001_0000 -> 4
  - 8'b0010_0000 -> 5
  - 8'b0100_0000 -> 6
  - 8'b1000_0000 -> 7
- bcd[3] is always 0 for a well-formed code.
- Well-formed means popcount(one_of_8) == 1.
- Malformed inputs (all-zero, or two or more bits set): bcd = 4'hF, error = 1. No priority resolution is applied.
- When in_valid = 1 at a rising edge: bcd, error and out_valid load from the decode of one_of_8.
- When in_valid = 0 at a rising edge: out_valid = 0, error = 0, and bcd holds its previous value.
- err_sticky next-state:
  - 0 if err_clr = 1 and no new error is captured that edge.
  - 1 if (in_valid & malformed) is captured, including the same edge as err_clr. Set wins over clear.
  - otherwise holds.
- X/Z on one_of_8 while in_valid = 0 has no effect on any output.

## Timing
- Latency is exactly 1 clk: input at edge n is reflected on the outputs after edge n.
- Throughput is one code per cycle; there is no back-pressure.
- Reset (rst_n = 0, asynchronous assert) forces:
  - bcd = 4'h0
  - out_valid = 0
  - error = 0
  - err_sticky = 0
- Reset deassertion is synchronised externally. The first capture happens on the first rising edge with rst_n = 1.
- If reset asserts while an input is in flight, that input is discarded and no output pulse is produced.
- Outputs are glitch-free because all are register outputs. There are no combinational input-to-output paths.

## Structure
- Shared package decoder_pkg holds:
  - ONEHOT_W = 8 and BCD_W = 4.
  - BCD_INVALID = 4'hF.
  - BCD_RESET = 4'h0.
- Sub-module onehot8_check: combinational; input 8-bit vector; outputs 3-bit index and is_onehot. It uses popcount plus an index OR-tree.
- The top level instantiates onehot8_check, selects between index and BCD_INVALID, and holds the output and sticky registers.

## Test plan
- Reset: hold rst_n = 0 with random inputs -> bcd = 0, out_valid = 0, error = 0, err_sticky = 0. Async check: assert rst_n mid-cycle and confirm outputs clear before the next edge.
- Sweep: in_valid = 1 and one_of_8 = 8'h01, 02, 04, 08, 10, 20, 40, 80 on consecutive cycles -> one cycle later bcd = 0..7 in order, error = 0, out_valid held high.
- Malformed: one_of_8 = 8'h00, then 8'h03, then 8'hFF with in_valid = 1 -> bcd = 4'hF, error = 1 on each, and err_sticky = 1 thereafter.
- Idle: in_valid = 0 with one_of_8 = 8'h00 after bcd = 5 -> out_valid = 0, error = 0, bcd stays 5, err_sticky unchanged.
- Sticky clear:
  - err_clr = 1 with a valid one-hot input -> err_sticky = 0.
  - err_clr = 1 together with one_of_8 = 8'h81 -> err_sticky remains 1.
- Random: 1000 cycles of random in_valid/one_of_8 compared against a reference model -> zero mismatches; the 1-cycle latency is checked on every sample.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared widths and code constants for the one-hot to BCD encoder.
package decoder_pkg;

  localparam int ONEHOT_W = 8;
  localparam int BCD_W    = 4;
  localparam int IDX_W    = 3;

  localparam logic [BCD_W-1:0] BCD_INVALID = 4'hF;
  localparam logic [BCD_W-1:0] BCD_RESET   = 4'h0;

endpackage

// File: rtl/onehot8_check.sv
// Combinational one-hot checker: popcount for validity, OR-tree for the bit index.
module onehot8_check
  import decoder_pkg::*;
(
  input  logic [ONEHOT_W-1:0] vec,
  output logic [IDX_W-1:0]    index,
  output logic                is_onehot
);

  logic [IDX_W:0] count;

  always_comb begin
    count = '0;
    for (int i = 0; i < ONEHOT_W; i++) begin
      count = count + {{IDX_W{1'b0}}, vec[i]};
    end
  end

  assign is_onehot = (count == {{IDX_W{1'b0}}, 1'b1});

  // Index bit b is the OR of every input bit whose position has bit b set;
  // only meaningful when is_onehot is high.
  for (genvar gi = 0; gi < IDX_W; gi++) begin : g_index
    logic [ONEHOT_W-1:0] mask;
    always_comb begin
      mask = '0;
      for (int i = 0; i < ONEHOT_W; i++) begin
        mask[i] = ((i >> gi) & 1) != 0;
      end
    end
    assign index[gi] = |(vec & mask);
  end

endmodule

// File: rtl/decoder_one_of_8_to_bcd.sv
// Registered one-hot-to-BCD encoder with per-sample and sticky malformed-code flags.
module decoder_one_of_8_to_bcd
  import decoder_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [ONEHOT_W-1:0] one_of_8,
  input  logic                err_clr,
  output logic [BCD_W-1:0]    bcd,
  output logic                out_valid,
  output logic                error,
  output logic                err_sticky
);

  logic [IDX_W-1:0] index;
  logic             is_onehot;
  logic [BCD_W-1:0] bcd_next;
  logic             capture_err;

  logic [BCD_W-1:0] bcd_reg;
  logic             out_valid_reg;
  logic             error_reg;
  logic             err_sticky_reg;

  onehot8_check u_check (
    .vec       (one_of_8),
    .index     (index),
    .is_onehot (is_onehot)
  );

  assign bcd_next    = is_onehot ? {1'b0, index} : BCD_INVALID;
  assign capture_err = in_valid & ~is_onehot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_reg        <= BCD_RESET;
      out_valid_reg  <= 1'b0;
      error_reg      <= 1'b0;
      err_sticky_reg <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      error_reg     <= capture_err;
      if (in_valid) begin
        bcd_reg <= bcd_next;
      end
      // A fresh malformed capture beats a clear on the same edge.
      if (capture_err) begin
        err_sticky_reg <= 1'b1;
      end else if (err_clr) begin
        err_sticky_reg <= 1'b0;
      end
    end
  end

  assign bcd        = bcd_reg;
  assign out_valid  = out_valid_reg;
  assign error      = error_reg;
  assign err_sticky = err_sticky_reg;

endmodule

// File: tb/tb_decoder_one_of_8_to_bcd.sv
// Directed-table and randomized checks of the registered one-hot-to-BCD encoder.
module tb_decoder_one_of_8_to_bcd;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] one_of_8;
  logic       err_clr;
  logic [3:0] bcd;
  logic       out_valid;
  logic       error;
  logic       err_sticky;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       in_valid;
    logic [7:0] one_of_8;
    logic       err_clr;
    logic [3:0] exp_bcd;
    logic       exp_valid;
    logic       exp_error;
    logic       exp_sticky;
  } vec_t;

  localparam int NVEC = 17;
  vec_t tbl [NVEC];

  decoder_one_of_8_to_bcd dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .one_of_8   (one_of_8),
    .err_clr    (err_clr),
    .bcd        (bcd),
    .out_valid  (out_valid),
    .error      (error),
    .err_sticky (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eb, input logic ev,
                         input logic ee, input logic es);
    chk({tag, ".bcd"}, {4'h0, bcd}, {4'h0, eb});
    chk({tag, ".out_valid"}, {7'h0, out_valid}, {7'h0, ev});
    chk({tag, ".error"}, {7'h0, error}, {7'h0, ee});
    chk({tag, ".err_sticky"}, {7'h0, err_sticky}, {7'h0, es});
  endtask

  // Advance one edge and land 1 time unit after it, clear of the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] m_bcd;
  logic       m_valid, m_error, m_sticky;
  logic       r_bad;
  int         r_err_before;

  initial begin
    // Sweep, malformed codes, idle hold, sticky clear / set-beats-clear, X while idle.
    tbl[0]  = '{1'b1, 8'h01, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'h02, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 8'h04, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 8'h08, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 8'h10, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 8'h20, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 8'h40, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 8'h80, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 8'h00, 1'b0, 4'hF, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 8'h03, 1'b0, 4'hF, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 8'hFF, 1'b0, 4'hF, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 8'h20, 1'b0, 4'd5, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 8'h01, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 8'h81, 1'b1, 4'hF, 1'b1, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 8'hxx, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 8'h00, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    one_of_8 = 8'h00;
    err_clr  = 1'b0;

    // Held in reset with random activity on the inputs.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'(($urandom_range(0, 1)));
      one_of_8 = 8'($urandom);
      err_clr  = 1'(($urandom_range(0, 1)));
      step();
    end
    chk_all("reset_hold", 4'h0, 1'b0, 1'b0, 1'b0);

    in_valid = 1'b0;
    err_clr  = 1'b0;
    #2 rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      in_valid = tbl[i].in_valid;
      one_of_8 = tbl[i].one_of_8;
      err_clr  = tbl[i].err_clr;
      step();
      $display("vec %0d: in_valid=%0b one_of_8=%h err_clr=%0b -> bcd=%h out_valid=%0b error=%0b sticky=%0b",
               i, tbl[i].in_valid, tbl[i].one_of_8, tbl[i].err_clr, bcd, out_valid, error, err_sticky);
      chk_all($sformatf("vec%0d", i), tbl[i].exp_bcd, tbl[i].exp_valid,
              tbl[i].exp_error, tbl[i].exp_sticky);
    end

    // Asynchronous reset mid-cycle with a malformed code in flight.
    in_valid = 1'b1;
    one_of_8 = 8'h06;
    err_clr  = 1'b0;
    step();
    chk_all("pre_async", 4'hF, 1'b1, 1'b1, 1'b1);
    in_valid = 1'b1;
    one_of_8 = 8'h40;
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_mid", 4'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("in_flight_drop", 4'h0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    step();
    chk_all("post_release", 4'h0, 1'b0, 1'b0, 1'b0);

    // Randomized run against a cycle model.
    m_bcd = 4'h0; m_valid = 1'b0; m_error = 1'b0; m_sticky = 1'b0;
    r_err_before = errors;
    for (int c = 0; c < 1000; c++) begin
      in_valid = 1'(($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 1) == 1) one_of_8 = 8'h01 << $urandom_range(0, 7);
      else                           one_of_8 = 8'($urandom);
      err_clr = 1'(($urandom_range(0, 7) == 0));
      r_bad = ($countones(one_of_8) != 1);
      if (in_valid) m_bcd = r_bad ? 4'hF : 4'($clog2(int'(one_of_8)));
      m_valid = in_valid;
      m_error = in_valid & r_bad;
      if (in_valid & r_bad) m_sticky = 1'b1;
      else if (err_clr)     m_sticky = 1'b0;
      step();
      chk_all($sformatf("rand%0d", c), m_bcd, m_valid, m_error, m_sticky);
    end
    $display("random run: 1000 cycles, %0d new errors", errors - r_err_before);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
